// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link parameters.
package uart_pkg;

    localparam int unsigned DEFAULT_SAMPLE_RATE = 16;
    localparam int unsigned DEFAULT_DATA_BITS   = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to all ones so idle-high
// lines do not glitch low out of reset.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with single-cycle valid and framing-error strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLE_RATE = DEFAULT_SAMPLE_RATE,
    parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 tick_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 framing_err_out,
    output logic                 parity_err_out
);

    localparam int unsigned TW = $clog2(SAMPLE_RATE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TickMid  = TW'(SAMPLE_RATE / 2 - 1);
    localparam logic [TW-1:0] TickLast = TW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] BitLast  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t StAfterData = StParity;
`else
    localparam rx_state_t StAfterData = StStop;
`endif

    logic                 rx_s;
    rx_state_t            state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 framing_err_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_q;
    logic                 parity_err_q;
`endif

    sync_2ff #(
        .Width (1)
    ) u_rx_sync (
        .clk_i  (clk_in),
        .rst_ni (rst_n_in),
        .d_i    (rx_in),
        .q_o    (rx_s)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= StIdle;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            framing_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q      <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            valid_q       <= 1'b0;
            framing_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
            if (tick_in) begin
                unique case (state_q)
                    StIdle: begin
                        if (!rx_s) begin
                            state_q    <= StStart;
                            tick_cnt_q <= '0;
                        end
                    end
                    StStart: begin
                        // Re-check mid start bit to reject short glitches.
                        if (tick_cnt_q == TickMid) begin
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            state_q    <= rx_s ? StIdle : StData;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                    StData: begin
                        if (tick_cnt_q == TickLast) begin
                            tick_cnt_q <= '0;
                            shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
                            bit_cnt_q  <= bit_cnt_q + BW'(1);
                            if (bit_cnt_q == BitLast) begin
                                state_q <= StAfterData;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    StParity: begin
                        if (tick_cnt_q == TickLast) begin
                            tick_cnt_q <= '0;
                            parity_q   <= rx_s;
                            state_q    <= StStop;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
`endif
                    StStop: begin
                        // Leaving mid stop bit lets the next start edge arrive half a bit later.
                        if (tick_cnt_q == TickLast) begin
                            tick_cnt_q <= '0;
                            if (rx_s) begin
                                data_q  <= shift_q;
                                state_q <= StIdle;
`ifdef UART_RX_PARITY_EN
                                if ((^shift_q) ^ parity_q) begin
                                    parity_err_q <= 1'b1;
                                end else begin
                                    valid_q <= 1'b1;
                                end
`else
                                valid_q <= 1'b1;
`endif
                            end else begin
                                framing_err_q <= 1'b1;
                                state_q       <= StBreak;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                    StBreak: begin
                        if (rx_s) begin
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign data_out        = data_q;
    assign valid_out       = valid_q;
    assign framing_err_out = framing_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_out  = parity_err_q;
`else
    assign parity_err_out  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-built serial frames at 16 ticks per bit, one tick every
// four clocks; covers reset, normal, back-to-back, glitch, framing and async-reset cases.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       framing_err_out;
    logic       parity_err_out;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int tdiv = 0;
    logic [7:0] rx_bytes[$];

    uart_rx #(
        .SAMPLE_RATE (16),
        .DATA_BITS   (8)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .tick_in         (tick),
        .rx_in           (rx),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .framing_err_out (framing_err_out),
        .parity_err_out  (parity_err_out)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tick = (tdiv == 3);
            tdiv = (tdiv + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (valid_out) begin
            valid_cnt++;
            rx_bytes.push_back(data_out);
        end
        if (framing_err_out) ferr_cnt++;
        if (parity_err_out) perr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!tick);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par,
                              input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(par);
        send_bit(stop);
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        ferr_cnt = 0;
        perr_cnt = 0;
        rx_bytes.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset data", 32'(data_out), 32'h0);
        check("reset valid", 32'(valid_out), 32'h0);
        check("reset ferr", 32'(framing_err_out), 32'h0);
        check("reset perr", 32'(parity_err_out), 32'h0);
        rst_n = 1'b1;
        wait_ticks(32);

        // Single frame, expected within 10 bit times.
        clear_counts();
        send_frame(8'b1001_0011, 1'b0, 1'b0, 1'b1);
        check("b93 valid count", 32'(valid_cnt), 32'd1);
        check("b93 data", 32'(data_out), 32'h93);
        check("b93 ferr count", 32'(ferr_cnt), 32'd0);
        check("b93 perr count", 32'(perr_cnt), 32'd0);
        wait_ticks(16);

        // Back-to-back frames with no idle gap.
        clear_counts();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        wait_ticks(16);
        check("b2b valid count", 32'(valid_cnt), 32'd2);
        check("b2b first", 32'(rx_bytes.size() > 0 ? rx_bytes[0] : 8'hxx), 32'hC3);
        check("b2b second", 32'(rx_bytes.size() > 1 ? rx_bytes[1] : 8'hxx), 32'h00);

        // Short low glitch is rejected.
        clear_counts();
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(32);
        check("glitch valid count", 32'(valid_cnt), 32'd0);
        check("glitch ferr count", 32'(ferr_cnt), 32'd0);
        check("glitch state idle", 32'(dut.state_q), 32'(StIdle));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        wait_ticks(16);
        check("post-glitch valid count", 32'(valid_cnt), 32'd1);
        check("post-glitch data", 32'(data_out), 32'h5A);

        // Bad stop bit followed by a long break.
        clear_counts();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        wait_ticks(20 * 16);
        check("break ferr count", 32'(ferr_cnt), 32'd1);
        check("break valid count", 32'(valid_cnt), 32'd0);
        check("break data held", 32'(data_out), 32'h5A);
        rx = 1'b1;
        wait_ticks(16);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_ticks(16);
        check("post-break valid count", 32'(valid_cnt), 32'd1);
        check("post-break data", 32'(data_out), 32'h3C);
        check("post-break ferr count", 32'(ferr_cnt), 32'd1);

        // Asynchronous reset in the middle of bit 4.
        clear_counts();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_ticks(8);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst data", 32'(data_out), 32'h0);
        check("async rst valid", 32'(valid_out), 32'h0);
        check("async rst ferr", 32'(framing_err_out), 32'h0);
        check("async rst state", 32'(dut.state_q), 32'(StIdle));
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ticks(32);
        check("reset frame valid count", 32'(valid_cnt), 32'd0);
        check("reset frame ferr count", 32'(ferr_cnt), 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        wait_ticks(16);
        check("post-reset valid count", 32'(valid_cnt), 32'd1);
        check("post-reset data", 32'(data_out), 32'h81);
        check("default perr count", 32'(perr_cnt), 32'd0);

`ifdef UART_RX_PARITY_EN
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        wait_ticks(16);
        check("parity good valid", 32'(valid_cnt), 32'd1);
        check("parity good perr", 32'(perr_cnt), 32'd0);
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        wait_ticks(16);
        check("parity bad valid", 32'(valid_cnt), 32'd0);
        check("parity bad perr", 32'(perr_cnt), 32'd1);
        check("parity bad data", 32'(data_out), 32'h07);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
